lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of core and memory addresses.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  core requests one load/store; sampled only in IDLE.
REQ-005 is_store  input  1  1 = store, 0 = load.
REQ-006 func3  input  3  RISC-V width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  ADDR_W  byte address.
REQ-008 store_val  input  32  rs2 value; low bytes used for SB/SH.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 load_val  output  32  extended load result, valid while done=1 and held until the next done.
REQ-012 misaligned  output  1  valid with done; access not naturally aligned.
REQ-013 illegal  output  1  valid with done; func3 undefined for the operation.
REQ-014 mem_req  output  1  memory request, held until granted.
REQ-015 mem_we  output  1  write request.
REQ-016 mem_addr  output  ADDR_W  word-aligned address, with bits [1:0] = 0.
REQ-017 mem_wstrb  output  4  byte-lane write enables.
REQ-018 mem_wdata  output  32  lane-shifted store data.
REQ-019 mem_gnt  input  1  memory accepts the request in the current cycle.
REQ-020 mem_rvalid  input  1  read data valid; arrives at least 1 cycle after the grant.
REQ-021 mem_rdata  input  32  aligned read word.

Function
REQ-022 States: IDLE, REQ, RESP, DONE.
REQ-023 In IDLE, start=1 latches is_store, func3, addr and store_val, then:
- goes to DONE if the access is illegal or misaligned;
- goes to REQ otherwise.
REQ-024 Illegal func3 values:
- loads: 011, 110, 111;
- stores: any value other than 000, 001, 010.
REQ-025 Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=00. Illegal takes priority over misaligned.
REQ-026 A faulting access issues no memory request; done asserts 2 cycles after start with load_val unchanged.
REQ-027 REQ: mem_req=1 with mem_we, mem_addr, mem_wstrb and mem_wdata stable until mem_gnt=1.
REQ-028 On grant in REQ, a store goes to DONE and a load goes to RESP.
REQ-029 RESP waits for mem_rvalid. On rvalid, load_val is registered and the state goes to DONE.
REQ-030 DONE drives done=1 for exactly one cycle, then returns to IDLE; the next start is accepted in that following IDLE cycle.
REQ-031 Minimum latency, start to done:
- store: 3 cycles (gnt in first REQ cycle);
- load: 4 cycles (rvalid 1 cycle after gnt).
REQ-032 Store strobes, with o = addr[1:0]:
- SB: 0001<<o;
- SH: 0011<<o;
- SW: 1111.
REQ-033 Store data: mem_wdata = store_val replicated per lane (byte x4, half x2). mem_we=0 and mem_wstrb=0000 for loads.
REQ-034 Load extract: byte = mem_rdata[8o+7:8o]; half = mem_rdata[16*addr[1]+15 : 16*addr[1]].
REQ-035 Load extension:
- LB: 24-bit sign extension;
- LH: 16-bit sign extension;
- LBU: 24 zero bits;
- LHU: 16 zero bits;
- LW: unchanged.
REQ-036 start is ignored while busy=1. mem_rvalid and mem_gnt are ignored outside RESP and REQ respectively.
REQ-037 mem_req is 0 in every state except REQ.

Reset
REQ-038 While rst=1 the next edge forces:
- state to IDLE;
- done, misaligned, illegal and mem_req to 0;
- load_val to 0 and latched operands to 0.
REQ-039 Reset mid-transaction abandons it. A late mem_rvalid after reset is ignored and produces no done.

Structure
REQ-040 A shared package riscv_pkg holds the func3 load/store constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the LSU state enumeration.
REQ-041 Lane formatting (strobe, write-data replication, extract, extension) is one combinational sub-module, lsu_align, instanced once. The FSM and registers stay in lsu_ctrl.

Verification
REQ-042 SW at addr=0x10, data 0xDEADBEEF, gnt immediate -> mem_addr=0x10, wstrb=1111, wdata=0xDEADBEEF, done at cycle 3, flags 0.
REQ-043 LB at addr=0x13, rdata=0x80000000 -> load_val=0xFFFFFF80. Same access as LBU -> load_val=0x00000080.
REQ-044 LH at addr=0x12, rdata=0x8001_0000 -> load_val=0xFFFF8001. LHU -> 0x00008001. SH at addr=0x12, data 0x1234 -> wstrb=1100, wdata=0x12341234.
REQ-045 LW at addr=0x11 -> mem_req never asserts, done 2 cycles after start, misaligned=1. Load with func3=011 -> illegal=1, misaligned=0.
REQ-046 Load with gnt delayed 3 cycles and rvalid delayed 5 cycles -> mem_req and its fields held constant through the wait, one done pulse, a second start during busy is ignored.
REQ-047 rst=1 in RESP, then rvalid=1 the cycle after reset releases -> state IDLE, no done, load_val=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store func3 codes, LSU state encoding and fault helpers.
package riscv_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_t;

  function automatic logic f_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store)
      return !((f3 == SB) || (f3 == SH) || (f3 == SW));
    else
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // func3[1:0] carries the access size for both loads and stores.
  function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane formatting: store strobes/data replication, load extract/extend.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_store_val,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_val
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift = i_rdata >> {i_offset, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_wstrb = 4'b1111;
    o_wdata = i_store_val;
    case (i_func3[1:0])
      2'b00: begin
        o_wstrb = 4'b0001 << i_offset;
        o_wdata = {4{i_store_val[7:0]}};
      end
      2'b01: begin
        o_wstrb = 4'b0011 << i_offset;
        o_wdata = {2{i_store_val[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_load_val = i_rdata;
    case (i_func3)
      LB:      o_load_val = {{24{w_byte[7]}}, w_byte};
      LH:      o_load_val = {{16{w_half[15]}}, w_half};
      LBU:     o_load_val = {24'd0, w_byte};
      LHU:     o_load_val = {16'd0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding access, word-aligned memory port.
module lsu_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_is_store,
  input  logic [2:0]        i_func3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_store_val,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_load_val,
  output logic              o_misaligned,
  output logic              o_illegal,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_wstrb,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [31:0]       i_mem_rdata
);

  lsu_state_t        r_state;
  logic              r_is_store;
  logic [2:0]        r_func3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_store_val;
  logic              r_mis_q;
  logic              r_ill_q;
  logic              r_done;
  logic              r_misaligned;
  logic              r_illegal;
  logic [31:0]       r_load_val;

  logic              w_ill_in;
  logic              w_mis_in;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load_ext;

  assign w_ill_in = f_illegal(i_is_store, i_func3);
  assign w_mis_in = !w_ill_in && f_misaligned(i_func3, i_addr[1:0]);

  lsu_align u_align (
    .i_func3     (r_func3),
    .i_offset    (r_addr[1:0]),
    .i_store_val (r_store_val),
    .i_rdata     (i_mem_rdata),
    .o_wstrb     (w_wstrb),
    .o_wdata     (w_wdata),
    .o_load_val  (w_load_ext)
  );

  // done and the fault flags are registered off ST_DONE, so they appear
  // in the IDLE cycle that follows it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_is_store   <= 1'b0;
      r_func3      <= 3'd0;
      r_addr       <= '0;
      r_store_val  <= 32'd0;
      r_mis_q      <= 1'b0;
      r_ill_q      <= 1'b0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_illegal    <= 1'b0;
      r_load_val   <= 32'd0;
    end else begin
      r_done       <= (r_state == ST_DONE);
      r_misaligned <= (r_state == ST_DONE) && r_mis_q;
      r_illegal    <= (r_state == ST_DONE) && r_ill_q;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_is_store  <= i_is_store;
            r_func3     <= i_func3;
            r_addr      <= i_addr;
            r_store_val <= i_store_val;
            r_mis_q     <= w_mis_in;
            r_ill_q     <= w_ill_in;
            r_state     <= (w_ill_in || w_mis_in) ? ST_DONE : ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_mem_gnt)
            r_state <= r_is_store ? ST_DONE : ST_RESP;
        end
        ST_RESP: begin
          if (i_mem_rvalid) begin
            r_load_val <= w_load_ext;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;
  assign o_load_val   = r_load_val;
  assign o_misaligned = r_misaligned;
  assign o_illegal    = r_illegal;
  assign o_mem_req    = (r_state == ST_REQ);
  assign o_mem_we     = r_is_store;
  assign o_mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign o_mem_wstrb  = r_is_store ? w_wstrb : 4'b0000;
  assign o_mem_wdata  = w_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  func3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_val = 32'd0;
  logic        busy, done, misaligned, illegal;
  logic [31:0] load_val;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int n_pass = 0;
  int n_total = 0;

  int          t_done_cyc, t_done_cnt;
  logic        t_req_seen, t_hold_bad, t_we, t_mis, t_ill, t_busy_end;
  logic [31:0] t_addr, t_wdata, t_lv;
  logic [3:0]  t_wstrb;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_is_store   (is_store),
    .i_func3      (func3),
    .i_addr       (addr),
    .i_store_val  (store_val),
    .o_busy       (busy),
    .o_done       (done),
    .o_load_val   (load_val),
    .o_misaligned (misaligned),
    .o_illegal    (illegal),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wstrb  (mem_wstrb),
    .o_mem_wdata  (mem_wdata),
    .i_mem_gnt    (mem_gnt),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata)
  );

  // Runs one access; cycle N is observed N edges after start was driven.
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sv, input logic [31:0] rd, input int gdly,
                         input int rdly, input int tail, input logic spur);
    int cyc, req_cnt, gnt_cyc;
    t_done_cyc = -1; t_done_cnt = 0; t_req_seen = 1'b0; t_hold_bad = 1'b0;
    t_addr = '0; t_wdata = '0; t_wstrb = '0; t_we = 1'b0;
    t_lv = '0; t_mis = 1'b0; t_ill = 1'b0;
    req_cnt = 0; gnt_cyc = -1;
    is_store = st; func3 = f3; addr = a; store_val = sv; mem_rdata = rd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc <= 40) begin
      if (done) begin
        if (t_done_cyc < 0) begin
          t_done_cyc = cyc; t_lv = load_val; t_mis = misaligned; t_ill = illegal;
        end
        t_done_cnt++;
      end
      if (mem_req) begin
        if (!t_req_seen) begin
          t_req_seen = 1'b1;
          t_addr = mem_addr; t_wdata = mem_wdata; t_wstrb = mem_wstrb; t_we = mem_we;
        end else if (mem_addr !== t_addr || mem_wdata !== t_wdata ||
                     mem_wstrb !== t_wstrb || mem_we !== t_we) begin
          t_hold_bad = 1'b1;
        end
      end
      if (t_done_cyc >= 0 && cyc >= t_done_cyc + tail) break;
      mem_gnt = mem_req && (req_cnt == gdly);
      if (mem_gnt) gnt_cyc = cyc;
      if (mem_req) req_cnt++;
      mem_rvalid = (gnt_cyc >= 0) && (cyc == gnt_cyc + rdly);
      if (spur && cyc == 2) begin
        start = 1'b1; is_store = 1'b1; func3 = 3'b010; addr = 32'h40; store_val = 32'h55AA55AA;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; start = 1'b0;
    t_busy_end = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else n_pass++;
    n_total++; if (mem_req !== 1'b0) $display("FAIL reset_req got=%b want=0", mem_req); else n_pass++;
    n_total++; if (load_val !== 32'h0) $display("FAIL reset_lv got=%h want=0", load_val); else n_pass++;
    n_total++; if ({misaligned, illegal} !== 2'b00) $display("FAIL reset_flags got=%b want=00", {misaligned, illegal}); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    run_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, 2, 1'b0);
    n_total++; if (t_addr !== 32'h10) $display("FAIL sw_addr got=%h want=00000010", t_addr); else n_pass++;
    n_total++; if (t_wstrb !== 4'b1111) $display("FAIL sw_wstrb got=%b want=1111", t_wstrb); else n_pass++;
    n_total++; if (t_wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata got=%h want=deadbeef", t_wdata); else n_pass++;
    n_total++; if (t_we !== 1'b1) $display("FAIL sw_we got=%b want=1", t_we); else n_pass++;
    n_total++; if (t_done_cyc != 3) $display("FAIL sw_latency got=%0d want=3", t_done_cyc); else n_pass++;
    n_total++; if ({t_mis, t_ill} !== 2'b00) $display("FAIL sw_flags got=%b want=00", {t_mis, t_ill}); else n_pass++;
    n_total++; if (t_done_cnt != 1) $display("FAIL sw_done_pulses got=%0d want=1", t_done_cnt); else n_pass++;
    run_txn(1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0, 0, 1, 1, 1'b0);
    n_total++; if (t_wstrb !== 4'b1100) $display("FAIL sh_wstrb got=%b want=1100", t_wstrb); else n_pass++;
    n_total++; if (t_wdata !== 32'h12341234) $display("FAIL sh_wdata got=%h want=12341234", t_wdata); else n_pass++;
    run_txn(1'b1, 3'b000, 32'h11, 32'h000000AB, 32'h0, 0, 1, 1, 1'b0);
    n_total++; if (t_wstrb !== 4'b0010) $display("FAIL sb_wstrb got=%b want=0010", t_wstrb); else n_pass++;
    n_total++; if (t_wdata !== 32'hABABABAB) $display("FAIL sb_wdata got=%h want=abababab", t_wdata); else n_pass++;
  endtask

  task automatic test_load();
    run_txn(1'b0, 3'b000, 32'h13, 32'h0, 32'h80000000, 0, 1, 1, 1'b0);
    n_total++; if (t_lv !== 32'hFFFFFF80) $display("FAIL lb_val got=%h want=ffffff80", t_lv); else n_pass++;
    n_total++; if (t_done_cyc != 4) $display("FAIL lb_latency got=%0d want=4", t_done_cyc); else n_pass++;
    n_total++; if ({t_we, t_wstrb} !== 5'b0) $display("FAIL lb_we_strb got=%b want=00000", {t_we, t_wstrb}); else n_pass++;
    n_total++; if (t_addr !== 32'h10) $display("FAIL lb_addr got=%h want=00000010", t_addr); else n_pass++;
    run_txn(1'b0, 3'b100, 32'h13, 32'h0, 32'h80000000, 0, 1, 1, 1'b0);
    n_total++; if (t_lv !== 32'h00000080) $display("FAIL lbu_val got=%h want=00000080", t_lv); else n_pass++;
    run_txn(1'b0, 3'b001, 32'h12, 32'h0, 32'h80010000, 0, 1, 1, 1'b0);
    n_total++; if (t_lv !== 32'hFFFF8001) $display("FAIL lh_val got=%h want=ffff8001", t_lv); else n_pass++;
    run_txn(1'b0, 3'b101, 32'h12, 32'h0, 32'h80010000, 0, 1, 1, 1'b0);
    n_total++; if (t_lv !== 32'h00008001) $display("FAIL lhu_val got=%h want=00008001", t_lv); else n_pass++;
  endtask

  task automatic test_fault();
    run_txn(1'b0, 3'b010, 32'h11, 32'h0, 32'hCAFEF00D, 0, 1, 1, 1'b0);
    n_total++; if (t_req_seen !== 1'b0) $display("FAIL lw_mis_req got=%b want=0", t_req_seen); else n_pass++;
    n_total++; if (t_done_cyc != 2) $display("FAIL lw_mis_latency got=%0d want=2", t_done_cyc); else n_pass++;
    n_total++; if ({t_mis, t_ill} !== 2'b10) $display("FAIL lw_mis_flags got=%b want=10", {t_mis, t_ill}); else n_pass++;
    n_total++; if (t_lv !== 32'h00008001) $display("FAIL lw_mis_lv_kept got=%h want=00008001", t_lv); else n_pass++;
    run_txn(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 0, 1, 1, 1'b0);
    n_total++; if ({t_mis, t_ill} !== 2'b01) $display("FAIL ld_ill_flags got=%b want=01", {t_mis, t_ill}); else n_pass++;
    n_total++; if (t_req_seen !== 1'b0) $display("FAIL ld_ill_req got=%b want=0", t_req_seen); else n_pass++;
    run_txn(1'b1, 3'b100, 32'h11, 32'h0, 32'h0, 0, 1, 1, 1'b0);
    n_total++; if ({t_mis, t_ill} !== 2'b01) $display("FAIL st_ill_prio got=%b want=01", {t_mis, t_ill}); else n_pass++;
    run_txn(1'b1, 3'b001, 32'h13, 32'h0, 32'h0, 0, 1, 1, 1'b0);
    n_total++; if ({t_mis, t_ill} !== 2'b10) $display("FAIL sh_mis_flags got=%b want=10", {t_mis, t_ill}); else n_pass++;
    n_total++; if (t_done_cyc != 2) $display("FAIL sh_mis_latency got=%0d want=2", t_done_cyc); else n_pass++;
  endtask

  task automatic test_wait_states();
    run_txn(1'b0, 3'b010, 32'h24, 32'h0, 32'h0BADF00D, 3, 5, 3, 1'b1);
    n_total++; if (t_hold_bad !== 1'b0) $display("FAIL wait_req_hold got=%b want=0", t_hold_bad); else n_pass++;
    n_total++; if (t_addr !== 32'h24) $display("FAIL wait_addr got=%h want=00000024", t_addr); else n_pass++;
    n_total++; if (t_done_cyc != 11) $display("FAIL wait_latency got=%0d want=11", t_done_cyc); else n_pass++;
    n_total++; if (t_done_cnt != 1) $display("FAIL wait_done_pulses got=%0d want=1", t_done_cnt); else n_pass++;
    n_total++; if (t_lv !== 32'h0BADF00D) $display("FAIL wait_lw_val got=%h want=0badf00d", t_lv); else n_pass++;
    n_total++; if (t_busy_end !== 1'b0) $display("FAIL wait_spur_start got=%b want=0", t_busy_end); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 3'b010, 32'h30, 32'h11112222, 32'h0, 0, 1, 0, 1'b0);
    run_txn(1'b1, 3'b000, 32'h32, 32'h000000C3, 32'h0, 0, 1, 0, 1'b0);
    n_total++; if (t_done_cyc != 3) $display("FAIL b2b_latency got=%0d want=3", t_done_cyc); else n_pass++;
    n_total++; if (t_wstrb !== 4'b0100) $display("FAIL b2b_wstrb got=%b want=0100", t_wstrb); else n_pass++;
    n_total++; if (t_addr !== 32'h30) $display("FAIL b2b_addr got=%h want=00000030", t_addr); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int dcount;
    is_store = 1'b0; func3 = 3'b010; addr = 32'h20; mem_rdata = 32'h12345678;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    n_total++; if ({busy, mem_req} !== 2'b10) $display("FAIL rmid_in_resp got=%b want=10", {busy, mem_req}); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_rvalid = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) dcount++;
      @(posedge clk); #1;
    end
    n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%b want=0", busy); else n_pass++;
    n_total++; if (dcount != 0) $display("FAIL rmid_done got=%0d want=0", dcount); else n_pass++;
    n_total++; if (load_val !== 32'h0) $display("FAIL rmid_lv got=%h want=00000000", load_val); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_fault();
    test_wait_states();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
